// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel bus timer.
package timer_pkg;

  localparam int CFG_EN_BIT = 0;
  localparam int CFG_AR_BIT = 1;
  localparam int CFG_PS_LSB = 2;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam ch_state_e RST_STATE = CH_IDLE;
  localparam logic      RST_FLAG  = 1'b0;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: prescaler, count/reload, config and sticky timeout flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_count,
  input  logic             load_cfg,
  input  logic             tick,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             flag
);

  localparam int CFG_W = PRESCALE_W + 2;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic [CFG_W-1:0]      cfg_q, cfg_d;
  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
  logic                  flag_q, flag_d;
  ch_state_e             state_q, state_d;

  logic [PRESCALE_W-1:0] ps;
  logic                  auto_reload;
  logic                  expire;

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    cfg_d       = cfg_q;
    pscnt_d     = pscnt_q;
    flag_d      = flag_q;
    expire      = 1'b0;
    ps          = cfg_q[CFG_PS_LSB +: PRESCALE_W];
    auto_reload = cfg_q[CFG_AR_BIT];

    if (state_q == CH_RUN && tick) begin
      if (pscnt_q == ps) begin
        pscnt_d = '0;
        if (count_q == WIDTH'(1)) begin
          expire  = 1'b1;
          count_d = (auto_reload && reload_q != '0) ? reload_q : '0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end else begin
        pscnt_d = pscnt_q + 1'b1;
      end
    end

    // A set from expiry beats a same-cycle acknowledge.
    if (ack) flag_d = 1'b0;
    if (expire) flag_d = 1'b1;

    if (load_count) begin
      count_d  = data_in;
      reload_d = data_in;
      pscnt_d  = '0;
      if (data_in != '0) flag_d = 1'b0;
    end

    if (load_cfg) cfg_d = data_in[CFG_W-1:0];

    state_d = (cfg_d[CFG_EN_BIT] && count_d != '0) ? CH_RUN : CH_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      reload_q <= '0;
      cfg_q    <= '0;
      pscnt_q  <= '0;
      flag_q   <= RST_FLAG;
      state_q  <= RST_STATE;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      cfg_q    <= cfg_d;
      pscnt_q  <= pscnt_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
    end
  end

  assign count = count_q;
  assign flag  = flag_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of countdown timers on the shared DATA bus: select decode, bus driver, timeout OR.
module timer_bank
  import timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int PRESCALE_W = 8,
  parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [WIDTH-1:0]  DATA,
  input  logic [SEL_W-1:0]  ch_select,
  input  logic              timer_in,
  input  logic              cfg_in,
  input  logic              timer_out,
  input  logic              tick,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] timeout,
  output logic              any_timeout,
  output logic [WIDTH-1:0]  REG_OUT_TIMER
);

  logic [NUM_CH-1:0]            load_count;
  logic [NUM_CH-1:0]            load_cfg;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_count;
  logic [WIDTH-1:0]             sel_count;

  // An out-of-range select matches no channel, so writes drop and reads return 0.
  always_comb begin
    load_count = '0;
    load_cfg   = '0;
    sel_count  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_select == SEL_W'(i)) begin
        load_count[i] = timer_in;
        load_cfg[i]   = cfg_in;
        sel_count     = ch_count[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .data_in    (DATA),
      .load_count (load_count[g]),
      .load_cfg   (load_cfg[g]),
      .tick       (tick),
      .ack        (ack[g]),
      .count      (ch_count[g]),
      .flag       (timeout[g])
    );
  end

  assign DATA          = timer_out ? sel_count : 'z;
  assign REG_OUT_TIMER = sel_count;
  assign any_timeout   = |timeout;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: register table, directed corner sequences, random vs. reference model.
module tb_timer_bank;

  localparam int WIDTH      = 16;
  localparam int NUM_CH     = 3;
  localparam int PRESCALE_W = 8;
  localparam int SEL_W      = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  wire  [WIDTH-1:0]  DATA;
  logic [SEL_W-1:0]  ch_select = '0;
  logic              timer_in = 1'b0;
  logic              cfg_in = 1'b0;
  logic              timer_out = 1'b0;
  logic              tick = 1'b0;
  logic [NUM_CH-1:0] ack = '0;
  logic [NUM_CH-1:0] timeout;
  logic              any_timeout;
  logic [WIDTH-1:0]  REG_OUT_TIMER;

  logic [WIDTH-1:0]  data_drv = '0;
  logic              drv_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one entry per channel.
  int m_count[NUM_CH];
  int m_reload[NUM_CH];
  int m_pscnt[NUM_CH];
  int m_ps[NUM_CH];
  bit m_en[NUM_CH];
  bit m_ar[NUM_CH];
  bit m_flag[NUM_CH];

  typedef struct {
    logic [1:0]  sel;
    logic        tin;
    logic        cin;
    logic [15:0] data;
    logic [1:0]  rd_sel;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  assign DATA = drv_en ? data_drv : 'z;

  timer_bank #(
    .WIDTH      (WIDTH),
    .NUM_CH     (NUM_CH),
    .PRESCALE_W (PRESCALE_W),
    .SEL_W      (SEL_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .DATA          (DATA),
    .ch_select     (ch_select),
    .timer_in      (timer_in),
    .cfg_in        (cfg_in),
    .timer_out     (timer_out),
    .tick          (tick),
    .ack           (ack),
    .timeout       (timeout),
    .any_timeout   (any_timeout),
    .REG_OUT_TIMER (REG_OUT_TIMER)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(timer_in && timer_out)) else $error("[TB] bus contention: timer_in and timer_out together");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_count[i] = 0; m_reload[i] = 0; m_pscnt[i] = 0; m_ps[i] = 0;
      m_en[i] = 0; m_ar[i] = 0; m_flag[i] = 0;
    end
  endtask

  // One clock edge of the behavioural model.
  task automatic model_step(input int sel, input bit tin, input bit cin, input bit tk,
                            input logic [NUM_CH-1:0] ackv, input int data);
    for (int i = 0; i < NUM_CH; i++) begin
      bit expire;
      int nc;
      int np;
      bit nf;
      expire = 0;
      nc = m_count[i];
      np = m_pscnt[i];
      nf = m_flag[i];
      if (m_en[i] && m_count[i] != 0 && tk) begin
        if (m_pscnt[i] == m_ps[i]) begin
          np = 0;
          if (m_count[i] == 1) begin
            expire = 1;
            nc = (m_ar[i] && m_reload[i] != 0) ? m_reload[i] : 0;
          end else begin
            nc = m_count[i] - 1;
          end
        end else begin
          np = (m_pscnt[i] + 1) & 255;
        end
      end
      if (ackv[i]) nf = 0;
      if (expire) nf = 1;
      if (tin && sel == i) begin
        nc = data;
        m_reload[i] = data;
        np = 0;
        if (data != 0) nf = 0;
      end
      if (cin && sel == i) begin
        m_en[i] = (data & 1) != 0;
        m_ar[i] = (data & 2) != 0;
        m_ps[i] = (data >> 2) & 255;
      end
      m_count[i] = nc;
      m_pscnt[i] = np;
      m_flag[i]  = nf;
    end
  endtask

  task automatic idle_inputs();
    timer_in = 0; cfg_in = 0; timer_out = 0; drv_en = 0; ack = '0; data_drv = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ch_select = SEL_W'($urandom);
      timer_in  = 1'($urandom);
      cfg_in    = 1'($urandom);
      timer_out = !timer_in && 1'($urandom);
      drv_en    = timer_in | cfg_in;
      data_drv  = WIDTH'($urandom);
      tick      = 1'($urandom);
      ack       = NUM_CH'($urandom);
      @(posedge clk); #1;
    end
    idle_inputs();
    tick = 0;
    model_reset();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] sel, input logic tin, input logic cin, input logic [15:0] data);
    ch_select = sel; timer_in = tin; cfg_in = cin; data_drv = data;
    drv_en = tin | cin; timer_out = 0;
    @(posedge clk); #1;
    timer_in = 0; cfg_in = 0; drv_en = 0;
  endtask

  task automatic run_edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_count(input string name, input logic [1:0] sel, input logic [15:0] exp);
    ch_select = sel;
    timer_out = 1;
    #1;
    check_output({name, "_bus"}, DATA, exp);
    check_output({name, "_reg"}, REG_OUT_TIMER, exp);
    timer_out = 0;
    #1;
  endtask

  initial begin
    logic [NUM_CH-1:0] exp_to;
    int op, sel, data, exp_sel;
    bit tk;
    logic [NUM_CH-1:0] ackv;

    tbl[0] = '{2'd0, 1'b1, 1'b0, 16'h0005, 2'd0, 16'h0005};
    tbl[1] = '{2'd1, 1'b1, 1'b0, 16'h00A0, 2'd1, 16'h00A0};
    tbl[2] = '{2'd2, 1'b1, 1'b0, 16'hBEEF, 2'd2, 16'hBEEF};
    tbl[3] = '{2'd3, 1'b1, 1'b0, 16'h1234, 2'd3, 16'h0000};
    tbl[4] = '{2'd0, 1'b0, 1'b0, 16'h0000, 2'd0, 16'h0005};
    tbl[5] = '{2'd1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h00A0};
    tbl[6] = '{2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 16'hBEEF};
    tbl[7] = '{2'd0, 1'b0, 1'b1, 16'h0001, 2'd0, 16'h0005};
    tbl[8] = '{2'd1, 1'b1, 1'b0, 16'h0000, 2'd1, 16'h0000};
    tbl[9] = '{2'd3, 1'b0, 1'b1, 16'hFFFF, 2'd2, 16'hBEEF};

    // Reset: outputs quiet while held, bus released, counts zero afterwards.
    do_reset();
    check_output("rst_timeout", timeout, 0);
    check_output("rst_any", any_timeout, 0);
    check_output("rst_reg", REG_OUT_TIMER, 0);
    data_drv = 16'h5A5A; drv_en = 1; #1;
    check_output("rst_bus_released", DATA, 16'h5A5A);
    drv_en = 0;
    release_reset();
    for (int i = 0; i < NUM_CH; i++) check_count($sformatf("rst_cnt%0d", i), 2'(i), 16'h0000);

    // Register table with tick held low.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(tbl[i].sel, tbl[i].tin, tbl[i].cin, tbl[i].data);
      check_count($sformatf("table%0d", i), tbl[i].rd_sel, tbl[i].exp);
      check_output($sformatf("table%0d_to", i), timeout, 0);
    end

    // One-shot on ch0, PS=0.
    do_reset(); release_reset();
    apply_stimulus(2'd0, 0, 1, 16'h0001);
    apply_stimulus(2'd0, 1, 0, 16'd5);
    tick = 1;
    run_edges(4);
    check_count("os_cnt4", 2'd0, 16'd1);
    check_output("os_to4", timeout[0], 1'b0);
    run_edges(1);
    check_output("os_to5", timeout[0], 1'b1);
    check_output("os_any5", any_timeout, 1'b1);
    check_count("os_cnt5", 2'd0, 16'd0);
    run_edges(3);
    check_count("os_hold", 2'd0, 16'd0);
    check_output("os_sticky", timeout[0], 1'b1);
    ack = 3'b001; run_edges(1); ack = '0;
    check_output("os_ack", timeout[0], 1'b0);

    // Prescale 3 with auto-reload on ch2.
    do_reset(); release_reset();
    apply_stimulus(2'd2, 0, 1, 16'h000F);
    apply_stimulus(2'd2, 1, 0, 16'd2);
    tick = 1;
    run_edges(7);
    check_output("ar_to7", timeout[2], 1'b0);
    check_count("ar_cnt7", 2'd2, 16'd1);
    run_edges(1);
    check_output("ar_to8", timeout[2], 1'b1);
    check_count("ar_reload", 2'd2, 16'd2);
    run_edges(3);
    check_count("ar_cnt11", 2'd2, 16'd2);
    run_edges(1);
    check_count("ar_cnt12", 2'd2, 16'd1);
    ack = 3'b100; run_edges(1); ack = '0;
    check_output("ar_ack", timeout[2], 1'b0);

    // Collisions on ch1: ack on the expiry edge, then load on a decrement edge.
    do_reset(); release_reset();
    apply_stimulus(2'd1, 0, 1, 16'h0003);
    apply_stimulus(2'd1, 1, 0, 16'd2);
    tick = 1;
    run_edges(1);
    check_count("col_cnt1", 2'd1, 16'd1);
    ack = 3'b010; run_edges(1); ack = '0;
    check_output("col_ack_set_wins", timeout[1], 1'b1);
    check_count("col_reload", 2'd1, 16'd2);
    apply_stimulus(2'd1, 1, 0, 16'd7);
    check_count("col_load_wins", 2'd1, 16'd7);
    check_output("col_flag_clr", timeout[1], 1'b0);
    run_edges(1);
    check_count("col_after", 2'd1, 16'd6);

    // Freeze and resume on ch0 with PS=1.
    do_reset(); release_reset();
    apply_stimulus(2'd0, 0, 1, 16'h0005);
    apply_stimulus(2'd0, 1, 0, 16'd5);
    tick = 1;
    run_edges(3);
    apply_stimulus(2'd0, 0, 1, 16'h0004);
    check_count("frz_cnt", 2'd0, 16'd3);
    run_edges(10);
    check_count("frz_hold", 2'd0, 16'd3);
    check_output("frz_to", timeout[0], 1'b0);
    apply_stimulus(2'd0, 0, 1, 16'h0005);
    run_edges(5);
    check_count("frz_cnt5", 2'd0, 16'd1);
    check_output("frz_to5", timeout[0], 1'b0);
    run_edges(1);
    check_output("frz_to6", timeout[0], 1'b1);
    check_count("frz_zero", 2'd0, 16'd0);

    // Randomized traffic against the reference model.
    do_reset(); release_reset();
    for (int n = 0; n < 1500; n++) begin
      op   = $urandom_range(0, 9);
      sel  = $urandom_range(0, 3);
      tk   = ($urandom_range(0, 3) != 0);
      ackv = NUM_CH'($urandom & $urandom & $urandom);
      data = 0;
      idle_inputs();
      case (op)
        0, 1: begin timer_in = 1; data = $urandom_range(0, 6); end
        2: begin
          cfg_in = 1;
          data = int'($urandom & 32'hFC00) | (int'($urandom_range(0, 2)) << 2)
               | (int'($urandom_range(0, 1)) << 1) | (($urandom_range(0, 3) != 0) ? 1 : 0);
        end
        3: begin timer_in = 1; cfg_in = 1; data = $urandom_range(1, 7); end
        4, 5: timer_out = 1;
        default: data = int'($urandom & 32'hFFFF);
      endcase
      drv_en    = !timer_out;
      data_drv  = WIDTH'(data);
      ch_select = SEL_W'(sel);
      tick      = tk;
      ack       = ackv;
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) exp_to[i] = m_flag[i];
      exp_sel = (sel < NUM_CH) ? m_count[sel] : 0;
      check_output($sformatf("rnd%0d_timeout", n), timeout, exp_to);
      check_output($sformatf("rnd%0d_any", n), any_timeout, |exp_to);
      check_output($sformatf("rnd%0d_reg", n), REG_OUT_TIMER, exp_sel);
      if (timer_out) check_output($sformatf("rnd%0d_bus", n), DATA, exp_sel);
      else check_output($sformatf("rnd%0d_bus_released", n), DATA, data);
      @(posedge clk);
      model_step(sel, timer_in, cfg_in, tk, ackv, data);
      #1;
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
